// File: rtl/mac_pe_ws.sv
// Weight-stationary systolic MAC cell: double-buffered weight, east/south
// forwarding, signed/unsigned product, saturating add and sticky overflow.
module mac_pe_ws #(
  parameter int bit_width  = 8,
  parameter int acc_width  = 32,
  parameter int mul_stages = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 signed_mode,
  input  logic                 sat_en,
  input  logic                 in_valid,
  input  logic [bit_width-1:0] data_in,
  input  logic [acc_width-1:0] acc_in,
  input  logic [bit_width-1:0] wt_in,
  input  logic                 wt_shift,
  input  logic                 wt_latch,
  input  logic                 ovf_clear,
  output logic [bit_width-1:0] data_out,
  output logic                 data_valid_out,
  output logic [bit_width-1:0] wt_out,
  output logic [acc_width-1:0] acc_out,
  output logic                 out_valid,
  output logic                 ovf_flag
);
  localparam int BW = bit_width;
  localparam int AW = acc_width;
  localparam int PW = 2 * bit_width;

  logic [BW-1:0] shadow_q, shadow_d;
  logic [BW-1:0] active_q, active_d;
  logic [BW-1:0] dout_q, dout_d;
  logic          dv_q;
  logic [AW-1:0] acc_q, acc_d;
  logic          ov_q;
  logic          ovf_q, ovf_d;

  logic signed [PW-1:0] prod_s;
  logic        [PW-1:0] prod_u;
  logic signed [AW-1:0] prod_se;
  logic        [AW-1:0] prod_ze;
  logic        [AW-1:0] prod;

  assign prod_s  = PW'($signed(data_in)) * PW'($signed(active_q));
  assign prod_u  = PW'(data_in) * PW'(active_q);
  assign prod_se = AW'(prod_s);
  assign prod_ze = AW'(prod_u);
  assign prod    = signed_mode ? prod_se : prod_ze;

  logic [AW-1:0] add_prod;
  logic          add_mode;
  logic          add_valid;

  // Two-stage variant registers the product so acc_in arrives one cycle later
  generate
    if (mul_stages == 2) begin : g_pipe
      logic [AW-1:0] p_q;
      logic          m_q;
      logic          v_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          p_q <= '0;
          m_q <= 1'b0;
          v_q <= 1'b0;
        end else begin
          v_q <= in_valid;
          if (in_valid) begin
            p_q <= prod;
            m_q <= signed_mode;
          end
        end
      end
      assign add_prod  = p_q;
      assign add_mode  = m_q;
      assign add_valid = v_q;
    end else begin : g_comb
      assign add_prod  = prod;
      assign add_mode  = signed_mode;
      assign add_valid = in_valid;
    end
  endgenerate

  logic [AW:0]   sum;
  logic [AW-1:0] res;
  logic [AW-1:0] sat_val;
  logic          ovf;

  always_comb begin
    sum     = {1'b0, acc_in} + {1'b0, add_prod};
    res     = sum[AW-1:0];
    ovf     = 1'b0;
    sat_val = '1;
    if (add_mode) begin
      ovf = (acc_in[AW-1] == add_prod[AW-1]) &&
            (res[AW-1] != acc_in[AW-1]);
      sat_val = acc_in[AW-1] ? {1'b1, {(AW-1){1'b0}}}
                             : {1'b0, {(AW-1){1'b1}}};
    end else begin
      ovf = sum[AW];
    end
  end

  always_comb begin
    shadow_d = wt_shift ? wt_in : shadow_q;
    active_d = wt_latch ? shadow_q : active_q;
    dout_d   = in_valid ? data_in : dout_q;
    acc_d    = acc_q;
    if (add_valid) acc_d = (ovf && sat_en) ? sat_val : res;
    ovf_d    = ovf_q;
    if (add_valid && ovf) ovf_d = 1'b1;
    else if (ovf_clear)   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      acc_q    <= '0;
      ov_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dout_q   <= dout_d;
      dv_q     <= in_valid;
      acc_q    <= acc_d;
      ov_q     <= add_valid;
      ovf_q    <= ovf_d;
    end
  end

  assign data_out       = dout_q;
  assign data_valid_out = dv_q;
  assign wt_out         = shadow_q;
  assign acc_out        = acc_q;
  assign out_valid      = ov_q;
  assign ovf_flag       = ovf_q;
endmodule

// File: tb/tb_mac_pe_ws.sv
// Scoreboard bench for mac_pe_ws: one stimulus stream drives a two-stage
// and a one-stage instance, each checked against an arithmetic model.
module tb_mac_pe_ws;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        signed_mode = 1'b0;
  logic        sat_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  data_in = '0;
  logic [15:0] acc_in = '0;
  logic [7:0]  wt_in = '0;
  logic        wt_shift = 1'b0;
  logic        wt_latch = 1'b0;
  logic        ovf_clear = 1'b0;

  logic [7:0]  dout2, dout1, wto2, wto1;
  logic        dv2, dv1, ov2, ov1, ovf2, ovf1;
  logic [15:0] acc2, acc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_pe_ws #(.bit_width(8), .acc_width(16), .mul_stages(2)) dut2 (
    .clk(clk), .reset(reset), .signed_mode(signed_mode),
    .sat_en(sat_en), .in_valid(in_valid), .data_in(data_in),
    .acc_in(acc_in), .wt_in(wt_in), .wt_shift(wt_shift),
    .wt_latch(wt_latch), .ovf_clear(ovf_clear),
    .data_out(dout2), .data_valid_out(dv2), .wt_out(wto2),
    .acc_out(acc2), .out_valid(ov2), .ovf_flag(ovf2));

  mac_pe_ws #(.bit_width(8), .acc_width(16), .mul_stages(1)) dut1 (
    .clk(clk), .reset(reset), .signed_mode(signed_mode),
    .sat_en(sat_en), .in_valid(in_valid), .data_in(data_in),
    .acc_in(acc_in), .wt_in(wt_in), .wt_shift(wt_shift),
    .wt_latch(wt_latch), .ovf_clear(ovf_clear),
    .data_out(dout1), .data_valid_out(dv1), .wt_out(wto1),
    .acc_out(acc1), .out_valid(ov1), .ovf_flag(ovf1));

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  function automatic int prodf(input logic [7:0] d,
                               input logic [7:0] w, input logic m);
    if (m) return int'($signed(d)) * int'($signed(w));
    return int'(d) * int'(w);
  endfunction

  // Returns {overflow, result}
  function automatic logic [16:0] addf(input logic [15:0] a, input int p,
                                       input logic m, input logic s);
    int x;
    if (m) begin
      x = int'($signed(a)) + p;
      if (x > 32767)  return {1'b1, s ? 16'h7FFF : 16'(x)};
      if (x < -32768) return {1'b1, s ? 16'h8000 : 16'(x)};
      return {1'b0, 16'(x)};
    end
    x = int'(a) + p;
    if (x > 65535) return {1'b1, s ? 16'hFFFF : 16'(x)};
    return {1'b0, 16'(x)};
  endfunction

  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [7:0]  m_sh = '0, m_act = '0, m_dout = '0;
  logic        m_dv = 1'b0, m_ovf1 = 1'b0, m_ovf2 = 1'b0;
  logic        pv = 1'b0, pm = 1'b0;
  int          pp = 0, pn = 0;
  logic [16:0] r1, r2;
  logic        n1, n2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sh = '0; m_act = '0; m_dout = '0; m_dv = 1'b0;
      m_ovf1 = 1'b0; m_ovf2 = 1'b0; pv = 1'b0; pm = 1'b0; pp = 0;
    end else begin
      pn = prodf(data_in, m_act, signed_mode);
      n1 = 1'b0;
      n2 = 1'b0;
      if (in_valid) begin
        r1 = addf(acc_in, pn, signed_mode, sat_en);
        n1 = r1[16];
        q1.push_back(r1[15:0]);
      end
      if (pv) begin
        r2 = addf(acc_in, pp, pm, sat_en);
        n2 = r2[16];
        q2.push_back(r2[15:0]);
      end
      m_ovf1 = n1 ? 1'b1 : (ovf_clear ? 1'b0 : m_ovf1);
      m_ovf2 = n2 ? 1'b1 : (ovf_clear ? 1'b0 : m_ovf2);
      pv = in_valid; pp = pn; pm = signed_mode;
      m_dv = in_valid;
      if (in_valid) m_dout = data_in;
      if (wt_latch) m_act = m_sh;
      if (wt_shift) m_sh = wt_in;
    end
  end

  logic [15:0] last1 = '0, last2 = '0, e;
  always @(negedge clk) begin
    if (reset) begin
      q1.delete(); q2.delete();
      last1 = '0; last2 = '0;
    end else begin
      if (ov1) begin
        if (q1.size() == 0) chk("ms1_unexpected_valid", 1, 0);
        else begin e = q1.pop_front(); last1 = e; chk("ms1_acc", acc1, e); end
      end else chk("ms1_acc_hold", acc1, last1);
      if (ov2) begin
        if (q2.size() == 0) chk("ms2_unexpected_valid", 1, 0);
        else begin e = q2.pop_front(); last2 = e; chk("ms2_acc", acc2, e); end
      end else chk("ms2_acc_hold", acc2, last2);
      chk("ms1_ovf", ovf1, m_ovf1);
      chk("ms2_ovf", ovf2, m_ovf2);
      chk("ms1_fwd", {dv1, dout1, wto1}, {m_dv, m_dout, m_sh});
      chk("ms2_fwd", {dv2, dout2, wto2}, {m_dv, m_dout, m_sh});
    end
  end

  task automatic drv(input logic v, input logic [7:0] d = 0,
                     input logic [15:0] a = 0, input logic m = 0,
                     input logic s = 0, input logic [7:0] wi = 0,
                     input logic sh = 0, input logic la = 0,
                     input logic clr = 0);
    in_valid = v; data_in = d; acc_in = a; signed_mode = m;
    sat_en = s; wt_in = wi; wt_shift = sh; wt_latch = la;
    ovf_clear = clr;
    @(negedge clk);
  endtask

  task automatic load_wt(input logic [7:0] w);
    drv(0, 0, 0, 0, 0, w, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk_zero(input string n);
    chk(n, {dout2, dv2, wto2, acc2, ov2, ovf2}, 0);
    chk({n, "_ms1"}, {dout1, dv1, wto1, acc1, ov1, ovf1}, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_zero("reset_async");
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset_state");

    // Basic unsigned MAC and forwarding latency
    load_wt(8'h05);
    drv(1, 8'd3, 16'd10, 0);
    chk("fwd_data", {dv2, dout2}, {1'b1, 8'd3});
    chk("ms2_not_yet", ov2, 0);
    drv(0, 0, 16'd10);
    chk("s1_acc", {ov2, acc2}, {1'b1, 16'h0019});

    // Signed then unsigned with mode travelling down the pipe
    load_wt(8'hFE);
    drv(1, 8'h7F, 0, 1);
    drv(1, 8'h7F, 0, 0);
    chk("s2_signed", {acc2, ovf2}, {16'hFF02, 1'b0});
    drv(0);
    chk("s2_unsigned", acc2, 16'h7E02);

    // Signed saturation and wrap
    load_wt(8'd4);
    drv(1, 8'd16, 16'h7FF0, 1, 1);
    drv(1, 8'd16, 16'h7FF0, 1, 1);
    chk("s3_sat", {acc2, ovf2}, {16'h7FFF, 1'b1});
    drv(0, 0, 16'h7FF0, 0, 0);
    chk("s3_wrap", {acc2, ovf2}, {16'h8030, 1'b1});
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("s3_clear", ovf2, 0);

    // Unsigned saturation and wrap
    load_wt(8'd1);
    drv(1, 8'd1, 16'hFFFF, 0, 1);
    drv(1, 8'd1, 16'hFFFF, 0, 1);
    chk("s4_sat", {acc2, ovf2}, {16'hFFFF, 1'b1});
    drv(0, 0, 16'hFFFF, 0, 0);
    chk("s4_wrap", {acc2, ovf2}, {16'h0000, 1'b1});
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Shift, latch and compute on one edge
    drv(0, 0, 0, 0, 0, 8'h02, 1, 0);
    drv(0, 0, 0, 0, 0, 8'h07, 1, 1);
    drv(1, 8'd10, 0, 0, 0, 8'h09, 1, 1);
    chk("s5_wt_out", wto2, 8'h09);
    drv(1, 8'd10, 0);
    chk("s5_old_active", acc2, 16'd20);
    drv(0);
    chk("s5_new_active", acc2, 16'd70);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom), 8'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0);
    end

    // Async reset in the middle of a burst
    for (int i = 0; i < 4; i++) drv(1, 8'($urandom), 16'($urandom), 1'($urandom));
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1 chk_zero("reset_mid");
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(0);
      chk("no_valid_after_reset", {ov1, ov2}, 0);
    end

    // Single-stage latency
    load_wt(8'h05);
    drv(1, 8'd3, 16'd10, 0);
    chk("s6_ms1_acc", {ov1, acc1}, {1'b1, 16'h0019});
    drv(0); drv(0);

    chk("ms1_drained", q1.size(), 0);
    chk("ms2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
